// File: rtl/fdma_wframe_sched.sv
`default_nettype none
// ============================================================================
// Module  : fdma_wframe_sched
// Brief   : uiFDMA write-side frame scheduler that drains a 128-bit line FIFO
//           into a ring of NUM_BUF DDR frame buffers, one burst per request.
// Option  : define FDMA_WFRAME_TIMEOUT_EN to build the REQ/XFER watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module fdma_wframe_sched #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter logic [31:0] BUF_STRIDE  = 32'h0080_0000,
  parameter int          NUM_BUF     = 3,
  parameter logic [31:0] FRAME_BEATS = 32'd600,
  parameter logic [15:0] BURST_LEN   = 16'd256,
  parameter int          FIFO_CNT_W  = 10,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
  input  logic                  ui_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic [FIFO_CNT_W-1:0] fifo_rcount,
  output logic                  fifo_rd,
  input  logic [1:0]            rd_buf_idx,
  output logic [31:0]           fdma_waddr,
  output logic                  fdma_wareq,
  output logic [15:0]           fdma_wsize,
  input  logic                  fdma_wbusy,
  input  logic                  fdma_wvalid,
  output logic [1:0]            wr_buf_idx,
  output logic [1:0]            done_buf_idx,
  output logic                  frame_done,
  output logic [7:0]            overrun_cnt,
  output logic                  burst_err,
  output logic                  timeout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_REQ  = 3'd2,
    S_XFER = 3'd3,
    S_NEXT = 3'd4
  } state_t;

  localparam logic [1:0] c_last_buf = 2'(NUM_BUF - 1);

  state_t      r_state, w_state_nxt;
  logic        r_wareq, r_wbusy_q, r_frame_done, r_burst_err;
  logic [31:0] r_waddr, r_beats_done;
  logic [15:0] r_wsize, r_beat_cnt;
  logic [1:0]  r_wr_buf, r_done_buf;
  logic [7:0]  r_overrun;

  logic        w_start, w_burst_end, w_frame_end, w_busy_fall, w_abort;
  logic [31:0] w_remain, w_addr, w_beats_sum;
  logic [15:0] w_cur_size, w_beats_final;
  logic [1:0]  w_nb1, w_nb2, w_buf_sel;

  assign w_remain    = FRAME_BEATS - r_beats_done;
  assign w_cur_size  = (w_remain > {16'd0, BURST_LEN}) ? BURST_LEN : w_remain[15:0];
  assign w_addr      = ADDR_BASE + ({30'd0, r_wr_buf} * BUF_STRIDE) + {r_beats_done[27:0], 4'b0000};
  assign w_beats_sum = r_beats_done + 32'(r_wsize);
  assign w_busy_fall = r_wbusy_q && !fdma_wbusy;
  // A beat coinciding with the busy fall still belongs to the burst.
  assign w_beats_final = r_beat_cnt + 16'(fdma_wvalid);

  // Skip the reader's buffer; with two buffers the second step lands back on done.
  assign w_nb1     = (r_done_buf == c_last_buf) ? 2'd0 : r_done_buf + 2'd1;
  assign w_nb2     = (w_nb1 == c_last_buf) ? 2'd0 : w_nb1 + 2'd1;
  assign w_buf_sel = (w_nb1 == rd_buf_idx) ? w_nb2 : w_nb1;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_burst_end = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start && enable && !fdma_wbusy) begin
          w_start     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (32'(fifo_rcount) >= 32'(w_cur_size)) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (r_wareq && fdma_wbusy) w_state_nxt = S_XFER;
      end
      S_XFER: begin
        if (w_busy_fall) begin
          w_burst_end = 1'b1;
          w_state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        w_frame_end = (w_beats_sum == FRAME_BEATS);
        w_state_nxt = w_frame_end ? S_IDLE : S_WAIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wareq      <= 1'b0;
      r_wbusy_q    <= 1'b0;
      r_waddr      <= ADDR_BASE;
      r_wsize      <= 16'd0;
      r_wr_buf     <= 2'd0;
      r_done_buf   <= c_last_buf;
      r_frame_done <= 1'b0;
      r_overrun    <= 8'd0;
      r_burst_err  <= 1'b0;
      r_beats_done <= 32'd0;
      r_beat_cnt   <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_wareq      <= (w_state_nxt == S_REQ);
      r_wbusy_q    <= fdma_wbusy;
      r_frame_done <= w_frame_end;
      if (w_start) begin
        r_wr_buf     <= w_buf_sel;
        r_beats_done <= 32'd0;
      end else if (r_state == S_NEXT) begin
        r_beats_done <= w_beats_sum;
      end
      // Address/size track WAIT and freeze from its exit through XFER.
      if (r_state == S_WAIT) begin
        r_wsize <= w_cur_size;
        r_waddr <= w_addr;
      end
      if (r_state == S_XFER) begin
        if (w_burst_end || w_abort) begin
          r_beat_cnt <= 16'd0;
          if (w_burst_end && (w_beats_final != r_wsize)) r_burst_err <= 1'b1;
        end else if (fdma_wvalid) begin
          r_beat_cnt <= r_beat_cnt + 16'd1;
        end
      end
      if (w_frame_end) r_done_buf <= r_wr_buf;
      if (frame_start && (r_state != S_IDLE) && (r_overrun != 8'hFF))
        r_overrun <= r_overrun + 8'd1;
    end
  end

`ifdef FDMA_WFRAME_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_timeout;
  logic        w_active;

  assign w_active = (r_state == S_REQ) || (r_state == S_XFER);
  assign w_abort  = w_active && (r_to_cnt == TIMEOUT_CYC - 16'd1);
  assign timeout  = r_timeout;

  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_active || w_abort || (fdma_wbusy && !r_wbusy_q) || fdma_wvalid)
        r_to_cnt <= 16'd0;
      else
        r_to_cnt <= r_to_cnt + 16'd1;
      if (w_abort) r_timeout <= 1'b1;
    end
  end
`else
  logic w_unused_to;
  assign w_unused_to = ^TIMEOUT_CYC;
  assign w_abort     = 1'b0;
  assign timeout     = 1'b0;
`endif

  assign fifo_rd      = (r_state == S_XFER) && fdma_wvalid;
  assign fdma_waddr   = r_waddr;
  assign fdma_wareq   = r_wareq;
  assign fdma_wsize   = r_wsize;
  assign wr_buf_idx   = r_wr_buf;
  assign done_buf_idx = r_done_buf;
  assign frame_done   = r_frame_done;
  assign overrun_cnt  = r_overrun;
  assign burst_err    = r_burst_err;

endmodule
`default_nettype wire

// File: tb/tb_fdma_wframe_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_fdma_wframe_sched
// Brief   : buffer-selection vector table, directed corner sequences and
//           randomized frames checked against a burst-list reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fdma_wframe_sched;

  localparam logic [31:0] c_addr_base = 32'h0000_0000;
  localparam logic [31:0] c_stride    = 32'h0080_0000;
  localparam int          c_num_buf   = 3;
  localparam int          c_frame     = 600;
  localparam int          c_burst     = 256;
  localparam int          c_to        = 4096;

  logic        ui_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        frame_start = 1'b0;
  logic [9:0]  fifo_rcount;
  logic        fifo_rd;
  logic [1:0]  rd_buf_idx = 2'd2;
  logic [31:0] fdma_waddr;
  logic        fdma_wareq;
  logic [15:0] fdma_wsize;
  logic        fdma_wbusy;
  logic        fdma_wvalid;
  logic [1:0]  wr_buf_idx, done_buf_idx;
  logic        frame_done;
  logic [7:0]  overrun_cnt;
  logic        burst_err, timeout;

  always #5 ui_clk = ~ui_clk;

  fdma_wframe_sched #(
    .ADDR_BASE(c_addr_base), .BUF_STRIDE(c_stride), .NUM_BUF(c_num_buf),
    .FRAME_BEATS(32'(c_frame)), .BURST_LEN(16'(c_burst)), .FIFO_CNT_W(10),
    .TIMEOUT_CYC(16'(c_to))
  ) dut (
    .ui_clk(ui_clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .fifo_rcount(fifo_rcount), .fifo_rd(fifo_rd), .rd_buf_idx(rd_buf_idx),
    .fdma_waddr(fdma_waddr), .fdma_wareq(fdma_wareq), .fdma_wsize(fdma_wsize),
    .fdma_wbusy(fdma_wbusy), .fdma_wvalid(fdma_wvalid), .wr_buf_idx(wr_buf_idx),
    .done_buf_idx(done_buf_idx), .frame_done(frame_done), .overrun_cnt(overrun_cnt),
    .burst_err(burst_err), .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  logic [9:0]  fifo_lvl_req = 10'd1023;
  logic        fifo_rand = 1'b0;
  logic        model_en = 1'b1;
  int          model_delay_max = 0;
  logic        hold_busy = 1'b0;
  int          short_idx = -1;

  logic [31:0] log_addr [0:255];
  logic [15:0] log_size [0:255];
  int          log_n = 0;
  int          fd_cnt = 0;
  int          rd_cnt = 0;

  typedef struct {
    logic [1:0] rd;
    logic [1:0] exp_wr;
    logic [1:0] exp_done;
  } vec_t;
  vec_t vecs [6];

  // FIFO level driver
  initial begin
    fifo_rcount = 10'd0;
    forever begin
      @(posedge ui_clk); #1;
      fifo_rcount = fifo_rand ? 10'($urandom) : fifo_lvl_req;
    end
  end

  // FDMA write-port model: logs each accepted burst, then streams its beats
  initial begin
    int d, nb;
    fdma_wbusy  = 1'b0;
    fdma_wvalid = 1'b0;
    forever begin
      @(posedge ui_clk); #1;
      if (model_en && fdma_wareq && !fdma_wbusy) begin
        d = int'($urandom_range(0, model_delay_max));
        repeat (d) begin @(posedge ui_clk); #1; end
        log_addr[log_n % 256] = fdma_waddr;
        log_size[log_n % 256] = fdma_wsize;
        nb = (log_n == short_idx) ? int'(fdma_wsize) - 1 : int'(fdma_wsize);
        log_n++;
        fdma_wbusy = 1'b1;
        @(posedge ui_clk); #1;
        for (int i = 0; i < nb; i++) begin
          fdma_wvalid = 1'b1;
          @(posedge ui_clk); #1;
        end
        fdma_wvalid = 1'b0;
        while (hold_busy) begin @(posedge ui_clk); #1; end
        fdma_wbusy = 1'b0;
      end
    end
  end

  always @(negedge ui_clk) begin
    if (frame_done) fd_cnt++;
    if (fifo_rd) rd_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ui_clk); #1;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_frame_done(input string name);
    int n = 0;
    while (!frame_done && n < 5000) begin tick(); n++; end
    checks++;
    if (!frame_done) begin
      errors++;
      $display("FAIL %s: frame_done not seen after %0d cycles", name, n);
    end
  endtask

  task automatic wait_wareq(input string name, input int budget);
    int n = 0;
    while (!fdma_wareq && n < budget) begin tick(); n++; end
    checks++;
    if (!fdma_wareq) begin
      errors++;
      $display("FAIL %s: fdma_wareq not seen after %0d cycles", name, n);
    end
  endtask

  function automatic logic [1:0] ref_next_buf(input int done, input int rd);
    int n;
    n = (done + 1) % c_num_buf;
    if (n == rd) n = (n + 1) % c_num_buf;
    return 2'(n);
  endfunction

  // Expected burst list of one frame: full bursts, remainder last
  task automatic check_bursts(input string name, input int first, input int bufi);
    int off = 0;
    int k = first;
    int sz;
    while (off < c_frame) begin
      sz = (c_frame - off < c_burst) ? c_frame - off : c_burst;
      check({name, "_addr"}, log_addr[k % 256], c_addr_base + 32'(bufi) * c_stride + 32'(off * 16));
      check({name, "_size"}, 32'(log_size[k % 256]), 32'(sz));
      off += sz;
      k++;
    end
    check({name, "_nburst"}, 32'(log_n - first), 32'(k - first));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_wareq"}, 32'(fdma_wareq), 32'd0);
    check({name, "_waddr"}, fdma_waddr, c_addr_base);
    check({name, "_wsize"}, 32'(fdma_wsize), 32'd0);
    check({name, "_wr_buf"}, 32'(wr_buf_idx), 32'd0);
    check({name, "_done_buf"}, 32'(done_buf_idx), 32'(c_num_buf - 1));
    check({name, "_frame_done"}, 32'(frame_done), 32'd0);
    check({name, "_overrun"}, 32'(overrun_cnt), 32'd0);
    check({name, "_burst_err"}, 32'(burst_err), 32'd0);
    check({name, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    int first, fd0, rd0, lat, n, ref_done, rdi;
    logic [1:0] exp_wr;
    logic seen;

    vecs[0] = '{2'd1, 2'd0, 2'd0};
    vecs[1] = '{2'd1, 2'd2, 2'd2};
    vecs[2] = '{2'd1, 2'd0, 2'd0};
    vecs[3] = '{2'd0, 2'd1, 2'd1};
    vecs[4] = '{2'd2, 2'd0, 2'd0};
    vecs[5] = '{2'd1, 2'd2, 2'd2};

    tick(); tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Single frame, FIFO already full
    rd_buf_idx = 2'd2;
    first = log_n; fd0 = fd_cnt; rd0 = rd_cnt;
    pulse_start();
    lat = 1;
    while (!fdma_wareq && lat < 20) begin tick(); lat++; end
    check("start_to_wareq_latency", 32'(lat), 32'd2);
    check("first_waddr", fdma_waddr, 32'h0);
    check("first_wsize", 32'(fdma_wsize), 32'd256);
    wait_frame_done("f1_done");
    repeat (5) tick();
    check_bursts("f1", first, 0);
    check("f1_frame_done_pulses", 32'(fd_cnt - fd0), 32'd1);
    check("f1_fifo_rd_beats", 32'(rd_cnt - rd0), 32'(c_frame));
    check("f1_done_buf", 32'(done_buf_idx), 32'd0);

    // Buffer ring selection table
    apply_reset();
    for (int v = 0; v < 6; v++) begin
      rd_buf_idx = vecs[v].rd;
      first = log_n;
      pulse_start();
      check($sformatf("vec%0d_wr_buf", v), 32'(wr_buf_idx), 32'(vecs[v].exp_wr));
      wait_frame_done($sformatf("vec%0d_done", v));
      tick();
      check($sformatf("vec%0d_done_buf", v), 32'(done_buf_idx), 32'(vecs[v].exp_done));
      check_bursts($sformatf("vec%0d", v), first, int'(vecs[v].exp_wr));
    end

    // FIFO starvation before the second burst
    apply_reset();
    rd_buf_idx = 2'd2;
    fifo_lvl_req = 10'd256;
    pulse_start();
    wait_wareq("starve_b1_req", 50);
    fifo_lvl_req = 10'd100;
    n = 0;
    while (fdma_waddr != 32'h1000 && n < 1000) begin tick(); n++; end
    check("starve_reach_b2_wait", fdma_waddr, 32'h1000);
    seen = 1'b0;
    repeat (30) begin tick(); if (fdma_wareq) seen = 1'b1; end
    check("starve_no_wareq", 32'(seen), 32'd0);
    fifo_lvl_req = 10'd256;
    wait_wareq("starve_b2_req", 50);
    check("starve_b2_waddr", fdma_waddr, 32'h1000);
    check("starve_b2_wsize", 32'(fdma_wsize), 32'd256);
    fifo_lvl_req = 10'd1023;
    wait_frame_done("starve_done");

    // frame_start pulses mid-frame
    apply_reset();
    first = log_n; rd0 = rd_cnt;
    pulse_start();
    repeat (20) tick();
    pulse_start();
    repeat (100) tick();
    pulse_start();
    tick();
    check("overrun_cnt", 32'(overrun_cnt), 32'd2);
    wait_frame_done("overrun_done");
    n = log_n;
    seen = 1'b0;
    repeat (30) begin tick(); if (fdma_wareq) seen = 1'b1; end
    check("overrun_beats", 32'(rd_cnt - rd0), 32'(c_frame));
    check("overrun_bursts", 32'(n - first), 32'd3);
    check("overrun_no_new_frame", 32'({seen, 31'(log_n - n)}), 32'd0);

    // Short first burst
    apply_reset();
    first = log_n;
    short_idx = log_n;
    pulse_start();
    check("berr_clear_at_start", 32'(burst_err), 32'd0);
    n = 0;
    while (fdma_waddr != 32'h1000 && n < 1000) begin tick(); n++; end
    check("berr_after_short", 32'(burst_err), 32'd1);
    wait_frame_done("berr_done");
    short_idx = -1;
    tick();
    check("berr_sticky", 32'(burst_err), 32'd1);
    check("berr_bursts", 32'(log_n - first), 32'd3);

    // Randomized frames: random FIFO level, FDMA grant delay, reader index
    apply_reset();
    fifo_rand = 1'b1;
    model_delay_max = 3;
    ref_done = c_num_buf - 1;
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        n = log_n;
        enable = 1'b0;
        pulse_start();
        repeat (5) tick();
        enable = 1'b1;
        check($sformatf("rnd%0d_disabled_start_dropped", f), 32'(log_n - n), 32'd0);
      end
      rdi = int'($urandom_range(0, c_num_buf - 1));
      rd_buf_idx = 2'(rdi);
      exp_wr = ref_next_buf(ref_done, rdi);
      first = log_n;
      pulse_start();
      check($sformatf("rnd%0d_wr_buf", f), 32'(wr_buf_idx), 32'(exp_wr));
      wait_frame_done($sformatf("rnd%0d_done", f));
      tick();
      check($sformatf("rnd%0d_done_buf", f), 32'(done_buf_idx), 32'(exp_wr));
      check_bursts($sformatf("rnd%0d", f), first, int'(exp_wr));
      ref_done = int'(exp_wr);
    end
    check("rnd_overrun", 32'(overrun_cnt), 32'd0);
    check("rnd_burst_err", 32'(burst_err), 32'd0);
    fifo_rand = 1'b0;
    model_delay_max = 0;

    // Reset during XFER with FDMA still busy
    apply_reset();
    hold_busy = 1'b1;
    rd_buf_idx = 2'd2;
    pulse_start();
    n = 0;
    while (!fdma_wvalid && n < 100) begin tick(); n++; end
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check_reset_vals("rst_xfer");
    rst = 1'b0;
    tick();
    check("rst_xfer_fifo_rd_idle", 32'(fifo_rd), 32'd0);
    pulse_start();
    seen = 1'b0;
    repeat (15) begin tick(); if (fdma_wareq) seen = 1'b1; end
    check("rst_busy_start_ignored", 32'(seen), 32'd0);
    check("rst_busy_wsize", 32'(fdma_wsize), 32'd0);
    hold_busy = 1'b0;
    n = 0;
    while (fdma_wbusy && n < 600) begin tick(); n++; end
    tick();
    first = log_n;
    pulse_start();
    check("rst_recover_wr_buf", 32'(wr_buf_idx), 32'd0);
    wait_frame_done("rst_recover_done");
    check_bursts("rst_recover", first, 0);

`ifdef FDMA_WFRAME_TIMEOUT_EN
    // FDMA never answers: watchdog abandons the frame
    apply_reset();
    model_en = 1'b0;
    fd0 = fd_cnt;
    pulse_start();
    wait_wareq("to_req", 20);
    n = 0;
    while (fdma_wareq && n < 5000) begin tick(); n++; end
    check("to_wareq_cycles", 32'(n), 32'(c_to));
    check("to_flag", 32'(timeout), 32'd1);
    check("to_done_buf", 32'(done_buf_idx), 32'(c_num_buf - 1));
    repeat (5) tick();
    check("to_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    check("to_stays_idle", 32'(fdma_wareq), 32'd0);
    model_en = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
